// File: rtl/miner_result_uart.sv
// Serialises a hex report of each miner result (found or exhausted) over an 8N1 UART.
// Inputs share the miner's clock domain; events are rising edges of found_i / exhausted_i.
module miner_result_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         found_i,
    input  logic         exhausted_i,
    input  logic [31:0]  nonce_i,
    input  logic [255:0] hash_i,
    output logic         uart_tx,
    output logic         tx_busy,
    output logic         overrun,
    output logic [7:0]   report_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop, StDone} state_e;

    state_e         state_q, state_d;
    logic           found_prev, exhausted_prev;
    logic           is_found_q, is_found_d;
    logic [6:0]     char_idx_q, char_idx_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [7:0]     shift_q, shift_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [255:0]   hash_q, hash_d;
    logic           tx_d, overrun_d;
    logic [7:0]     count_d;

    logic           found_edge, exh_edge, any_edge, bit_end;
    logic [6:0]     last_idx;
    logic [2:0]     nk;
    logic [5:0]     hk;
    logic [3:0]     nib;
    logic [7:0]     char_byte;

    assign found_edge = found_i & ~found_prev;
    assign exh_edge   = exhausted_i & ~exhausted_prev;
    assign any_edge   = found_edge | exh_edge;
    assign bit_end    = (baud_q == BaudLast);
    assign last_idx   = is_found_q ? 7'd76 : 7'd2;

    // Digit offsets within the nonce (chars 2..9) and hash (chars 11..74) fields, MS nibble first.
    assign nk = char_idx_q[2:0] - 3'd2;
    assign hk = char_idx_q[5:0] - 6'd11;

    always_comb begin
        nib       = 4'h0;
        char_byte = 8'h0A;
        if (!is_found_q) begin
            case (char_idx_q)
                7'd0:    char_byte = 8'h58;
                7'd1:    char_byte = 8'h0D;
                default: char_byte = 8'h0A;
            endcase
        end else if (char_idx_q == 7'd0) begin
            char_byte = 8'h46;
        end else if (char_idx_q == 7'd1 || char_idx_q == 7'd10) begin
            char_byte = 8'h20;
        end else if (char_idx_q <= 7'd74) begin
            nib = (char_idx_q <= 7'd9) ? nonce_q[{~nk, 2'b00} +: 4] : hash_q[{~hk, 2'b00} +: 4];
            char_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (char_idx_q == 7'd75) begin
            char_byte = 8'h0D;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_found_d = is_found_q;
        char_idx_d = char_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        shift_d    = shift_q;
        nonce_d    = nonce_q;
        hash_d     = hash_q;
        count_d    = report_count;
        overrun_d  = overrun | (any_edge & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (any_edge) begin
                    nonce_d    = nonce_i;
                    hash_d     = hash_i;
                    is_found_d = found_edge;
                    char_idx_d = 7'd0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                shift_d   = char_byte;
                baud_d    = '0;
                bit_idx_d = 3'd0;
                state_d   = StStart;
            end
            StStart: begin
                baud_d = bit_end ? '0 : baud_q + CntW'(1);
                if (bit_end) state_d = StData;
            end
            StData: begin
                baud_d = bit_end ? '0 : baud_q + CntW'(1);
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                baud_d = bit_end ? '0 : baud_q + CntW'(1);
                if (bit_end) begin
                    if (char_idx_q == last_idx) begin
                        state_d = StDone;
                    end else begin
                        char_idx_d = char_idx_q + 7'd1;
                        state_d    = StLoad;
                    end
                end
            end
            StDone: begin
                count_d = report_count + 8'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        tx_d = 1'b1;
        if (state_d == StStart)     tx_d = 1'b0;
        else if (state_d == StData) tx_d = shift_d[0];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            found_prev     <= 1'b0;
            exhausted_prev <= 1'b0;
            is_found_q     <= 1'b0;
            char_idx_q     <= 7'd0;
            bit_idx_q      <= 3'd0;
            baud_q         <= '0;
            shift_q        <= 8'h00;
            nonce_q        <= 32'h0;
            hash_q         <= 256'h0;
            uart_tx        <= 1'b1;
            tx_busy        <= 1'b0;
            overrun        <= 1'b0;
            report_count   <= 8'h00;
        end else begin
            state_q        <= state_d;
            found_prev     <= found_i;
            exhausted_prev <= exhausted_i;
            is_found_q     <= is_found_d;
            char_idx_q     <= char_idx_d;
            bit_idx_q      <= bit_idx_d;
            baud_q         <= baud_d;
            shift_q        <= shift_d;
            nonce_q        <= nonce_d;
            hash_q         <= hash_d;
            uart_tx        <= tx_d;
            tx_busy        <= (state_d != StIdle);
            overrun        <= overrun_d;
            report_count   <= count_d;
        end
    end

endmodule

// File: tb/tb_miner_result_uart.sv
// Randomised bench: a string-level report model feeds a byte scoreboard, and a UART
// decoder pops and compares every byte seen on the line.
module tb_miner_result_uart;

    localparam int C = 4;
    localparam int FoundCycles = 77 * (10 * C + 1) + 1;
    localparam int ExhCycles   = 3 * (10 * C + 1) + 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         found_i, exhausted_i;
    logic [31:0]  nonce_i;
    logic [255:0] hash_i;
    logic         uart_tx, tx_busy, overrun;
    logic [7:0]   report_count;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_count = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    miner_result_uart #(.CLKS_PER_BIT(C)) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .found_i     (found_i),
        .exhausted_i (exhausted_i),
        .nonce_i     (nonce_i),
        .hash_i      (hash_i),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .overrun     (overrun),
        .report_count(report_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    // Reference report: "F <8 hex nonce> <64 hex hash>\r\n" or "X\r\n".
    function automatic void push_report(input bit f, input logic [31:0] n, input logic [255:0] h);
        logic [255:0] t;
        if (f) begin
            exp_q.push_back(8'h46);
            exp_q.push_back(8'h20);
            for (int k = 7; k >= 0; k--) exp_q.push_back(hex_char(int'((n >> (4 * k)) & 32'hF)));
            exp_q.push_back(8'h20);
            for (int k = 63; k >= 0; k--) begin
                t = h >> (4 * k);
                exp_q.push_back(hex_char(int'(t[3:0])));
            end
        end else begin
            exp_q.push_back(8'h58);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // UART monitor: samples at negedges, mid-bit, aborts on reset.
    initial begin
        bit mact = 0;
        int mcnt = 0;
        logic [7:0] rx = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mact = 0;
            end else if (!mact) begin
                if (uart_tx === 1'b0) begin
                    mact = 1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt == C / 2) begin
                    check("start_bit", uart_tx, 0);
                    if (uart_tx !== 1'b0) mact = 0;
                end else if (mcnt < C / 2 + 9 * C && (mcnt - C / 2) % C == 0) begin
                    rx = {uart_tx, rx[7:1]};
                end else if (mcnt == C / 2 + 9 * C) begin
                    check("stop_bit", uart_tx, 1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx);
                    end else begin
                        check("uart_byte", rx, exp_q.pop_front());
                    end
                    mact = 0;
                end
            end
        end
    end

    task automatic start_event(input bit f, input bit e, input logic [31:0] n,
                               input logic [255:0] h, input bit hold);
        @(posedge clk); #1;
        nonce_i = n; hash_i = h; found_i = f; exhausted_i = e;
        if (f || e) push_report(f, n, h);
        @(posedge clk); #1;
        if (!hold) begin
            found_i = 1'b0;
            exhausted_i = 1'b0;
        end
    endtask

    // Called just after the capture edge (or first_cnt cycles later); counts busy cycles.
    task automatic measure_report(input int exp_cycles, input int first_cnt);
        int cnt = first_cnt;
        forever begin
            @(negedge clk);
            if (cnt == 0) check("busy_rise", tx_busy, 1);
            if (cnt == 1) check("start_latency", uart_tx, 0);
            if (!tx_busy || cnt > 5000) break;
            cnt++;
        end
        check("report_duration", cnt, exp_cycles);
        exp_count = exp_count + 8'd1;
        check("report_count", report_count, exp_count);
        check("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [255:0] h;
        int busy_seen;
        reset_n = 1'b0; found_i = 1'b0; exhausted_i = 1'b0; nonce_i = '0; hash_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", uart_tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", report_count, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;

        // Idle line after reset
        busy_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || report_count !== 8'h00) busy_seen++;
        end
        check("idle_200", busy_seen, 0);

        // Directed found report
        start_event(1, 0, 32'h7C2BAC1D, 256'h1, 0);
        measure_report(FoundCycles, 0);

        // Exhausted held high: one report, no retrigger
        start_event(0, 1, '0, '0, 1);
        measure_report(ExhCycles, 0);
        busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_busy) busy_seen++;
        end
        check("no_retrigger", busy_seen, 0);
        check("exh_count_stable", report_count, exp_count);
        exhausted_i = 1'b0;
        repeat (3) @(posedge clk);

        // Simultaneous edges: found wins, no overrun
        start_event(1, 1, $urandom, {8{$urandom}}, 0);
        measure_report(FoundCycles, 0);
        check("both_no_overrun", overrun, 0);

        // Second edge mid-report plus input churn
        h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_event(1, 0, $urandom, h, 0);
        repeat (100) @(posedge clk);
        #1;
        found_i = 1'b1; nonce_i = ~nonce_i; hash_i = ~h;
        @(posedge clk); #1;
        found_i = 1'b0;
        check("overrun_set", overrun, 1);
        measure_report(FoundCycles, 101);
        busy_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_busy) busy_seen++;
        end
        check("overrun_single_report", busy_seen, 0);

        // Reset during char 10 (' ' start/low bits span capture+411..+434)
        start_event(1, 0, $urandom, {8{$urandom}}, 0);
        repeat (419) @(posedge clk);
        #1;
        check("pre_reset_low", uart_tx, 0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_tx_high", uart_tx, 1);
        check("reset_busy", tx_busy, 0);
        exp_count = 8'h00;
        check("reset_count", report_count, exp_count);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        start_event(1, 0, $urandom, {8{$urandom}}, 0);
        measure_report(FoundCycles, 0);

        for (int r = 0; r < 3; r++) begin
            start_event(1, 0, $urandom, {8{$urandom}}, 0);
            measure_report(FoundCycles, 0);
        end

        // Run short reports until the counter wraps to zero
        while (exp_count != 8'h00) begin
            start_event(0, 1, '0, '0, 0);
            measure_report(ExhCycles, 0);
        end
        check("count_wrapped", report_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
